alu16: RTL and testbench

- 16-bit, 8-operation arithmetic/logic unit with registered result and status flags.
- Sits in the 16-bit processor datapath between register-file read ports and write-back.
- One operation is accepted per cycle when in_valid is high; the result appears one cycle later, qualified by out_valid.

---
 rtl/alu16_pkg.sv | 44 ++++
 rtl/alu16_shifter.sv | 46 ++++
 rtl/alu16.sv | 111 +++++++++++
 tb/tb_alu16.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_pkg
//  Description : Shared mode codes, flag record and helpers for the 16-bit ALU.
//  Revision    : 1.0 - initial release
// ============================================================================

package alu16_pkg;

    localparam logic [2:0] MODE_ADD = 3'd0;
    localparam logic [2:0] MODE_SUB = 3'd1;
    localparam logic [2:0] MODE_SHR = 3'd2;
    localparam logic [2:0] MODE_SHL = 3'd3;
    localparam logic [2:0] MODE_AND = 3'd4;
    localparam logic [2:0] MODE_OR  = 3'd5;
    localparam logic [2:0] MODE_NOT = 3'd6;
    localparam logic [2:0] MODE_XOR = 3'd7;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    // Two's-complement overflow from operand and result sign bits.
    function automatic logic signed_ovf(
        input logic a_sign,
        input logic b_sign,
        input logic r_sign,
        input logic is_sub
    );
        if (is_sub) begin
            return (a_sign != b_sign) && (r_sign != a_sign);
        end
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu16_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu16_shifter
//  Description : Combinational logarithmic barrel shifter, logical left/right,
//                with the last bit shifted out.
//  Revision    : 1.0 - initial release
// ============================================================================

module alu16_shifter
    import alu16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [WIDTH-1:0]   shifted,
    output logic               shift_out
);

    logic [WIDTH-1:0] w_data_rev;
    logic [WIDTH-1:0] w_out_rev;
    logic [WIDTH-1:0] w_core_in;
    logic [WIDTH:0]   w_stage [0:SHAMT_W];

    // Left shifts run through the same right-shift core on bit-reversed data;
    // the extra LSB guard bit catches the last bit shifted out either way.
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_data_rev[i] = data[WIDTH-1-i];
        assign w_out_rev[i]  = w_stage[SHAMT_W][WIDTH-i];
    end

    assign w_core_in  = (dir == SHIFT_LEFT) ? w_data_rev : data;
    assign w_stage[0] = {w_core_in, 1'b0};

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        assign w_stage[k+1] = shamt[k] ? (w_stage[k] >> (2 ** k)) : w_stage[k];
    end

    assign shifted   = (dir == SHIFT_LEFT) ? w_out_rev : w_stage[SHAMT_W][WIDTH:1];
    assign shift_out = w_stage[SHAMT_W][0];

endmodule

`default_nettype wire

// File: rtl/alu16.sv
`default_nettype none
// ============================================================================
//  Module      : alu16
//  Description : 16-bit, 8-operation ALU with registered result, status flags
//                and single-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================

module alu16
    import alu16_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_shifted;
    logic             w_shift_out;
    logic             w_shift_dir;
    logic [WIDTH-1:0] w_result;
    flags_t           w_flags;

    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;
    logic             r_out_valid;

    // Bit WIDTH of the difference is the borrow (in1 < in2 unsigned).
    assign w_sum  = {1'b0, in1} + {1'b0, in2};
    assign w_diff = {1'b0, in1} - {1'b0, in2};

    assign w_shift_dir = (mode == MODE_SHL) ? SHIFT_LEFT : SHIFT_RIGHT;

    alu16_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data      (in1),
        .shamt     (in2[SHAMT_W-1:0]),
        .dir       (w_shift_dir),
        .shifted   (w_shifted),
        .shift_out (w_shift_out)
    );

    always_comb begin
        w_result  = '0;
        w_flags   = '0;
        case (mode)
            MODE_ADD: begin
                w_result  = w_sum[WIDTH-1:0];
                w_flags.c = w_sum[WIDTH];
                w_flags.v = signed_ovf(in1[WIDTH-1], in2[WIDTH-1], w_sum[WIDTH-1], 1'b0);
            end
            MODE_SUB: begin
                w_result  = w_diff[WIDTH-1:0];
                w_flags.c = w_diff[WIDTH];
                w_flags.v = signed_ovf(in1[WIDTH-1], in2[WIDTH-1], w_diff[WIDTH-1], 1'b1);
            end
            MODE_SHR,
            MODE_SHL: begin
                w_result  = w_shifted;
                w_flags.c = w_shift_out;
            end
            MODE_AND: w_result = in1 & in2;
            MODE_OR:  w_result = in1 | in2;
            MODE_NOT: w_result = ~in1;
            MODE_XOR: w_result = in1 ^ in2;
            default:  w_result = '0;
        endcase
        w_flags.z = (w_result == '0);
        w_flags.n = w_result[WIDTH-1];
    end

    // Idle cycles drop out_valid but keep the last result and flags visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign result    = r_result;
    assign out_valid = r_out_valid;
    assign flag_z    = r_flags.z;
    assign flag_n    = r_flags.n;
    assign flag_c    = r_flags.c;
    assign flag_v    = r_flags.v;

endmodule

`default_nettype wire

// File: tb/tb_alu16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu16
//  Description : Scoreboard bench for alu16 driven by hand-computed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_alu16;
    import alu16_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  mode;
    logic [15:0] result;
    logic        out_valid;
    logic        flag_z;
    logic        flag_n;
    logic        flag_c;
    logic        flag_v;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        string       name;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] last_res = '0;
    logic [3:0]  last_flg = '0;

    alu16 #(
        .WIDTH   (16),
        .SHAMT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .result    (result),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Flags are given as 4'bZNCV.
    task automatic issue(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [3:0] f, input string nm);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        in1      = a;
        in2      = b;
        e.res    = r;
        e.flg    = f;
        e.name   = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in1      = 16'($urandom);
            in2      = 16'($urandom);
            mode     = 3'($urandom);
        end
    endtask

    // Monitor: every cycle, out_valid must match whether a result is owed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last_res = '0;
                last_flg = '0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, 32'(result), 32'(e.res));
                    check({e.name, " flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(e.flg));
                    last_res = e.res;
                    last_flg = e.flg;
                end
            end else begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check({e.name, " out_valid"}, 32'(out_valid), 32'd1);
                end
                check("hold result", 32'(result), 32'(last_res));
                check("hold flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(last_flg));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        mode     = '0;
        #3;
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(MODE_ADD, 16'd200,  16'd300,  16'h01F4, 4'b0000, "add_basic");
        issue(MODE_SHL, 16'h00F0, 16'd15,   16'h0000, 4'b1000, "shl_15");
        issue(MODE_SHL, 16'h00F0, 16'd4,    16'h0F00, 4'b0000, "shl_4");
        issue(MODE_SHL, 16'h8001, 16'd1,    16'h0002, 4'b0010, "shl_carry");
        issue(MODE_SHL, 16'h8001, 16'h0010, 16'h8001, 4'b0100, "shl_zero_upper_ignored");
        issue(MODE_SUB, 16'd5,    16'd7,    16'hFFFE, 4'b0110, "sub_borrow");
        issue(MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, "sub_ovf");
        issue(MODE_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b1000, "sub_equal");
        issue(MODE_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, "add_ovf");
        issue(MODE_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, "add_carry");
        issue(MODE_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1011, "add_neg_ovf");
        issue(MODE_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, "and");
        issue(MODE_OR,  16'hF0F0, 16'hFF00, 16'hFFF0, 4'b0100, "or");
        issue(MODE_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000, "xor");
        issue(MODE_NOT, 16'hF0F0, 16'hFF00, 16'h0F0F, 4'b0000, "not_a");
        issue(MODE_NOT, 16'hF0F0, 16'h1234, 16'h0F0F, 4'b0000, "not_b");
        issue(MODE_SHR, 16'h8001, 16'd1,    16'h4000, 4'b0010, "shr_carry");
        issue(MODE_SHR, 16'h00F0, 16'd4,    16'h000F, 4'b0000, "shr_4");
        issue(MODE_SHR, 16'hFFFF, 16'd15,   16'h0001, 4'b0010, "shr_15");
        issue(MODE_SHR, 16'h00F0, 16'h0013, 16'h001E, 4'b0000, "shr_upper_ignored");
        idle(2);

        issue(MODE_ADD, 16'd200,  16'd300,  16'h01F4, 4'b0000, "b2b_add");
        issue(MODE_SUB, 16'd5,    16'd7,    16'hFFFE, 4'b0110, "b2b_sub");
        issue(MODE_SHR, 16'h8001, 16'd1,    16'h4000, 4'b0010, "b2b_shr");
        issue(MODE_SHL, 16'h8001, 16'd1,    16'h0002, 4'b0010, "b2b_shl");
        issue(MODE_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0100, "b2b_and");
        issue(MODE_OR,  16'hF0F0, 16'hFF00, 16'hFFF0, 4'b0100, "b2b_or");
        issue(MODE_NOT, 16'hF0F0, 16'hFF00, 16'h0F0F, 4'b0000, "b2b_not");
        issue(MODE_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b0000, "b2b_xor");
        idle(3);

        // Mid-stream asynchronous reset discards the operation in flight.
        issue(MODE_ADD, 16'h1234, 16'h0001, 16'h1235, 4'b0000, "pre_reset");
        issue(MODE_ADD, 16'h0003, 16'h0004, 16'h0007, 4'b0000, "discarded");
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("async reset result", 32'(result), 32'd0);
        check("async reset flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(MODE_ADD, 16'h0003, 16'h0004, 16'h0007, 4'b0000, "post_reset_add");
        idle(2);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
